// File: rtl/miss_msg_det_pkg.sv
// Shared MoldUDP64 defaults (field widths, session-gap limit) and the
// packet classification used by the miss detector.
package miss_msg_det_pkg;

    localparam int SEQ_NUM_W_DEF = 64;
    localparam int SID_W_DEF     = 80;
    localparam int ML_W_DEF      = 16;

    // Session jumps larger than this are treated as a resync, not a loss.
    localparam logic [79:0] SID_GAP_MAX_DEF = 80'h1 << 63;

    typedef enum logic [2:0] {
        PK_IDLE,
        PK_INORDER,
        PK_SEQ_GAP,
        PK_LATE,
        PK_SID_GAP,
        PK_SID_RESYNC,
        PK_SID_OLD
    } pkt_kind_e;

endpackage

// File: rtl/miss_msg_det.sv
// MoldUDP64 missed-message detector: tracks expected session/sequence and
// reports gaps. Build option MISS_SID_DET_EN enables session-gap reporting.
module miss_msg_det
    import miss_msg_det_pkg::*;
#(
    parameter int               SEQ_NUM_W   = SEQ_NUM_W_DEF,
    parameter int               SID_W       = SID_W_DEF,
    parameter int               ML_W        = ML_W_DEF,
    parameter logic [SID_W-1:0] SID_GAP_MAX = SID_W'(SID_GAP_MAX_DEF)
) (
    input  logic                 clk,
    input  logic                 nreset,

    input  logic                 v_i,
    input  logic [SID_W-1:0]     sid_i,
    input  logic [SEQ_NUM_W-1:0] seq_num_i,
    input  logic [ML_W-1:0]      msg_cnt_i,
    input  logic                 eos_i,

    output logic                 miss_seq_num_v_o,
    output logic [SID_W-1:0]     miss_seq_num_sid_o,
    output logic [SEQ_NUM_W-1:0] miss_seq_num_start_o,
    output logic [SEQ_NUM_W-1:0] miss_seq_num_cnt_o,

    output logic                 miss_sid_v_o,
    output logic [SID_W-1:0]     miss_sid_start_o,
    output logic [SEQ_NUM_W-1:0] miss_sid_seq_num_start_o,
    output logic [SID_W-1:0]     miss_sid_cnt_o,
    output logic [SEQ_NUM_W-1:0] miss_sid_seq_num_end_o
);

    // Valid-only outputs: each *_v_o is a single-cycle pulse with no
    // back-pressure; its data fields are meaningful only while it is high.

    logic [SID_W-1:0]     sid_q;
    logic [SEQ_NUM_W-1:0] seq_q;

    logic                 r_seq_v;
    logic [SID_W-1:0]     r_seq_sid;
    logic [SEQ_NUM_W-1:0] r_seq_start;
    logic [SEQ_NUM_W-1:0] r_seq_cnt;

    pkt_kind_e            w_kind;
    logic [SID_W-1:0]     w_sid_diff;
    logic [SEQ_NUM_W-1:0] w_seq_diff;
    logic [SEQ_NUM_W-1:0] w_seq_next;
    logic                 w_same_sid;

    assign w_sid_diff = sid_i - sid_q;
    assign w_seq_diff = seq_num_i - seq_q;
    assign w_seq_next = seq_num_i + SEQ_NUM_W'(msg_cnt_i) + SEQ_NUM_W'(1);
    assign w_same_sid = (w_kind == PK_INORDER) || (w_kind == PK_SEQ_GAP) ||
                        (w_kind == PK_LATE);

    always_comb begin
        w_kind = PK_IDLE;
        if (v_i) begin
            if (sid_i == sid_q) begin
                if (seq_num_i == seq_q)
                    w_kind = PK_INORDER;
                else if (seq_num_i > seq_q)
                    w_kind = PK_SEQ_GAP;
                else
                    w_kind = PK_LATE;
            end else if (sid_i > sid_q) begin
                if (w_sid_diff <= SID_GAP_MAX)
                    w_kind = PK_SID_GAP;
                else
                    w_kind = PK_SID_RESYNC;
            end else begin
                w_kind = PK_SID_OLD;
            end
        end
    end

    // EOS only closes the session it names; an EOS for another session
    // follows the ordinary session rules.
    always_ff @(posedge clk) begin
        if (nreset) begin
            sid_q       <= '0;
            seq_q       <= '0;
            r_seq_v     <= 1'b0;
            r_seq_sid   <= '0;
            r_seq_start <= '0;
            r_seq_cnt   <= '0;
        end else begin
            r_seq_v <= 1'b0;
            case (w_kind)
                PK_INORDER: seq_q <= w_seq_next;
                PK_SEQ_GAP: begin
                    r_seq_v     <= 1'b1;
                    r_seq_sid   <= sid_q;
                    r_seq_start <= seq_q;
                    r_seq_cnt   <= w_seq_diff;
                    seq_q       <= w_seq_next;
                end
                PK_SID_GAP, PK_SID_RESYNC: begin
                    sid_q <= sid_i;
                    seq_q <= w_seq_next;
                end
                default: ;
            endcase
            if (w_same_sid && eos_i) begin
                sid_q <= sid_q + SID_W'(1);
                seq_q <= '0;
            end
        end
    end

    assign miss_seq_num_v_o     = r_seq_v;
    assign miss_seq_num_sid_o   = r_seq_sid;
    assign miss_seq_num_start_o = r_seq_start;
    assign miss_seq_num_cnt_o   = r_seq_cnt;

`ifdef MISS_SID_DET_EN
    logic                 r_sid_v;
    logic [SID_W-1:0]     r_sid_start;
    logic [SEQ_NUM_W-1:0] r_sid_seq_start;
    logic [SID_W-1:0]     r_sid_cnt;
    logic [SEQ_NUM_W-1:0] r_sid_seq_end;

    always_ff @(posedge clk) begin
        if (nreset) begin
            r_sid_v         <= 1'b0;
            r_sid_start     <= '0;
            r_sid_seq_start <= '0;
            r_sid_cnt       <= '0;
            r_sid_seq_end   <= '0;
        end else begin
            r_sid_v <= 1'b0;
            if (w_kind == PK_SID_GAP) begin
                r_sid_v         <= 1'b1;
                r_sid_start     <= sid_q;
                r_sid_seq_start <= seq_q;
                r_sid_cnt       <= w_sid_diff;
                r_sid_seq_end   <= seq_num_i;
            end
        end
    end

    assign miss_sid_v_o             = r_sid_v;
    assign miss_sid_start_o         = r_sid_start;
    assign miss_sid_seq_num_start_o = r_sid_seq_start;
    assign miss_sid_cnt_o           = r_sid_cnt;
    assign miss_sid_seq_num_end_o   = r_sid_seq_end;
`else
    assign miss_sid_v_o             = 1'b0;
    assign miss_sid_start_o         = '0;
    assign miss_sid_seq_num_start_o = '0;
    assign miss_sid_cnt_o           = '0;
    assign miss_sid_seq_num_end_o   = '0;
`endif

endmodule

// File: tb/tb_miss_msg_det.sv
// Bench for miss_msg_det: directed scenarios followed by random packets,
// checked against a rule-level model of the expected session/sequence.
module tb_miss_msg_det;

    localparam int SEQ_NUM_W = 18;
    localparam int SID_W     = 80;
    localparam int ML_W      = 16;
    localparam logic [SID_W-1:0] GAP_MAX = 80'h1 << 63;
`ifdef MISS_SID_DET_EN
    localparam logic SID_DET = 1'b1;
`else
    localparam logic SID_DET = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic nreset = 1'b1;
    always #5 clk = ~clk;

    logic                 v_i = 1'b0;
    logic [SID_W-1:0]     sid_i = '0;
    logic [SEQ_NUM_W-1:0] seq_num_i = '0;
    logic [ML_W-1:0]      msg_cnt_i = '0;
    logic                 eos_i = 1'b0;

    logic                 miss_seq_num_v_o;
    logic [SID_W-1:0]     miss_seq_num_sid_o;
    logic [SEQ_NUM_W-1:0] miss_seq_num_start_o;
    logic [SEQ_NUM_W-1:0] miss_seq_num_cnt_o;
    logic                 miss_sid_v_o;
    logic [SID_W-1:0]     miss_sid_start_o;
    logic [SEQ_NUM_W-1:0] miss_sid_seq_num_start_o;
    logic [SID_W-1:0]     miss_sid_cnt_o;
    logic [SEQ_NUM_W-1:0] miss_sid_seq_num_end_o;

    miss_msg_det #(
        .SEQ_NUM_W (SEQ_NUM_W),
        .SID_W     (SID_W),
        .ML_W      (ML_W)
    ) dut (
        .clk                      (clk),
        .nreset                   (nreset),
        .v_i                      (v_i),
        .sid_i                    (sid_i),
        .seq_num_i                (seq_num_i),
        .msg_cnt_i                (msg_cnt_i),
        .eos_i                    (eos_i),
        .miss_seq_num_v_o         (miss_seq_num_v_o),
        .miss_seq_num_sid_o       (miss_seq_num_sid_o),
        .miss_seq_num_start_o     (miss_seq_num_start_o),
        .miss_seq_num_cnt_o       (miss_seq_num_cnt_o),
        .miss_sid_v_o             (miss_sid_v_o),
        .miss_sid_start_o         (miss_sid_start_o),
        .miss_sid_seq_num_start_o (miss_sid_seq_num_start_o),
        .miss_sid_cnt_o           (miss_sid_cnt_o),
        .miss_sid_seq_num_end_o   (miss_sid_seq_num_end_o)
    );

    // ---------------- reference model state ----------------
    logic [SID_W-1:0]     m_sid;
    logic [SEQ_NUM_W-1:0] m_seq;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".sid_q"}, 128'(dut.sid_q), 128'(m_sid));
        chk({tag, ".seq_q"}, 128'(dut.seq_q), 128'(m_seq));
    endtask

    // Drive one cycle of input, predict the outcome from the protocol rules,
    // then compare outputs and expected state just after the clock edge.
    task automatic send(input string tag, input logic v, input logic [SID_W-1:0] sid,
                        input logic [SEQ_NUM_W-1:0] seq, input logic [ML_W-1:0] cnt,
                        input logic eos);
        logic                 e_seq_v, e_sid_v;
        logic [SID_W-1:0]     e_seq_sid, e_sid_start, e_sid_cnt;
        logic [SEQ_NUM_W-1:0] e_seq_start, e_seq_cnt, e_sid_sstart, e_sid_send, nxt;
        e_seq_v = 1'b0; e_sid_v = 1'b0;
        e_seq_sid = '0; e_sid_start = '0; e_sid_cnt = '0;
        e_seq_start = '0; e_seq_cnt = '0; e_sid_sstart = '0; e_sid_send = '0;
        @(negedge clk);
        v_i = v; sid_i = sid; seq_num_i = seq; msg_cnt_i = cnt; eos_i = eos;
        nxt = seq + SEQ_NUM_W'(cnt) + SEQ_NUM_W'(1);
        if (v) begin
            if (sid == m_sid) begin
                if (seq > m_seq) begin
                    e_seq_v = 1'b1; e_seq_sid = m_sid;
                    e_seq_start = m_seq; e_seq_cnt = seq - m_seq;
                end
                if (eos) begin
                    m_sid = m_sid + 1'b1; m_seq = '0;
                end else if (seq >= m_seq) begin
                    m_seq = nxt;
                end
            end else if (sid > m_sid) begin
                if (SID_DET && (sid - m_sid) <= GAP_MAX) begin
                    e_sid_v = 1'b1; e_sid_start = m_sid; e_sid_sstart = m_seq;
                    e_sid_cnt = sid - m_sid; e_sid_send = seq;
                end
                m_sid = sid; m_seq = nxt;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".seq_v"}, 128'(miss_seq_num_v_o), 128'(e_seq_v));
        chk({tag, ".sid_v"}, 128'(miss_sid_v_o), 128'(e_sid_v));
        if (e_seq_v) begin
            chk({tag, ".seq_sid"}, 128'(miss_seq_num_sid_o), 128'(e_seq_sid));
            chk({tag, ".seq_start"}, 128'(miss_seq_num_start_o), 128'(e_seq_start));
            chk({tag, ".seq_cnt"}, 128'(miss_seq_num_cnt_o), 128'(e_seq_cnt));
        end
        if (e_sid_v) begin
            chk({tag, ".sid_start"}, 128'(miss_sid_start_o), 128'(e_sid_start));
            chk({tag, ".sid_sstart"}, 128'(miss_sid_seq_num_start_o), 128'(e_sid_sstart));
            chk({tag, ".sid_cnt"}, 128'(miss_sid_cnt_o), 128'(e_sid_cnt));
            chk({tag, ".sid_send"}, 128'(miss_sid_seq_num_end_o), 128'(e_sid_send));
        end
        check_state(tag);
    endtask

    // Reset for one edge with the given packet on the inputs; it must be discarded.
    task automatic do_reset(input string tag, input logic v, input logic [SID_W-1:0] sid,
                            input logic [SEQ_NUM_W-1:0] seq);
        @(negedge clk);
        nreset = 1'b1; v_i = v; sid_i = sid; seq_num_i = seq; msg_cnt_i = '0; eos_i = 1'b0;
        m_sid = '0; m_seq = '0;
        @(posedge clk);
        #1;
        chk({tag, ".seq_v"}, 128'(miss_seq_num_v_o), 128'(0));
        chk({tag, ".sid_v"}, 128'(miss_sid_v_o), 128'(0));
        chk({tag, ".seq_data"}, {miss_seq_num_sid_o, 16'(miss_seq_num_start_o),
                                 16'(miss_seq_num_cnt_o)}, 128'(0));
        chk({tag, ".sid_data"}, 128'(miss_sid_start_o) | 128'(miss_sid_cnt_o) |
            128'(miss_sid_seq_num_start_o) | 128'(miss_sid_seq_num_end_o), 128'(0));
        check_state(tag);
        @(negedge clk);
        nreset = 1'b0; v_i = 1'b0;
    endtask

    // ---------------- directed then random stimulus ----------------
    initial begin
        logic [SID_W-1:0]     sid;
        logic [SEQ_NUM_W-1:0] seq;
        logic [ML_W-1:0]      cnt;
        logic                 v, eos;
        m_sid = '0; m_seq = '0;

        do_reset("reset", 1'b0, '0, '0);

        send("inorder0", 1'b1, 80'd0, 18'd0, 16'd5, 1'b0);
        send("inorder1", 1'b1, 80'd0, 18'd6, 16'd3, 1'b0);
        send("seqgap", 1'b1, 80'd0, 18'd20, 16'd1, 1'b0);
        send("pulse_end", 1'b0, 80'd0, 18'd0, 16'd0, 1'b0);
        send("eos", 1'b1, 80'd0, 18'd22, 16'd0, 1'b1);
        send("new_sess", 1'b1, 80'd1, 18'd0, 16'd4, 1'b0);
        send("sidgap", 1'b1, 80'd4, 18'd7, 16'd0, 1'b0);
        send("late", 1'b1, 80'd4, 18'd2, 16'd9, 1'b0);
        send("old_sid", 1'b1, 80'd2, 18'd50, 16'd1, 1'b0);
        send("seq_wrap", 1'b1, 80'd4, 18'd8, 16'hFFFF, 1'b0);
        send("gap_max", 1'b1, 80'd4 + GAP_MAX, 18'd3, 16'd0, 1'b0);
        send("resync", 1'b1, 80'd4 + GAP_MAX + GAP_MAX + 80'd1, 18'd9, 16'd0, 1'b0);
        send("gap_pend", 1'b1, dut.sid_q, 18'd200, 16'd0, 1'b0);
        do_reset("mid_reset", 1'b1, 80'd0, 18'd40);
        send("post_reset", 1'b0, 80'd0, 18'd0, 16'd0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            v = 1'b1; sid = m_sid; seq = m_seq; eos = 1'b0;
            cnt = ML_W'($urandom_range(0, 20));
            case ($urandom_range(0, 9))
                0, 1, 2: ;
                3: seq = m_seq + SEQ_NUM_W'($urandom_range(1, 30));
                4: seq = m_seq - SEQ_NUM_W'($urandom_range(1, 5));
                5: begin eos = 1'b1; seq = m_seq + SEQ_NUM_W'($urandom_range(0, 3)); end
                6: sid = m_sid + SID_W'($urandom_range(1, 6));
                7: sid = m_sid - SID_W'($urandom_range(1, 3));
                8: sid = m_sid + GAP_MAX + SID_W'($urandom_range(0, 1));
                default: begin
                    v = 1'($urandom_range(0, 1));
                    seq = SEQ_NUM_W'($urandom);
                    cnt = ML_W'($urandom);
                    eos = 1'($urandom_range(0, 1));
                end
            endcase
            send("rand", v, sid, seq, cnt, eos);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
